radix4_divider_32bit: RTL

RADIX4_DIVIDER_32BIT -- requirements
Module: radix4_divider_32bit

---
 rtl/pe_arith_pkg.sv | 25 ++
 rtl/div_r4_step.sv | 30 +++
 rtl/radix4_divider_32bit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pe_arith_pkg.sv
// Shared arithmetic definitions for the divider and multiplier datapaths.
package pe_arith_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ITER_COUNT = 16;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ITER_COUNT - 1);
  localparam logic [XLEN-1:0]  DIV0_QUOT   = '1;
  localparam logic [XLEN-1:0]  OVF_QUOT    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  OVF_DIVISOR = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } div_state_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? ('0 - v) : v;
  endfunction

endpackage

// File: rtl/div_r4_step.sv
// One radix-4 restoring step: pick the largest multiple of D not exceeding
// the shifted partial remainder and subtract it.
module div_r4_step
  import pe_arith_pkg::*;
(
  input  logic [XLEN+1:0] i_prem,
  input  logic [XLEN+1:0] i_d,
  input  logic [XLEN+1:0] i_d2,
  input  logic [XLEN+1:0] i_d3,
  output logic [XLEN+1:0] o_rem,
  output logic [1:0]      o_digit
);

  // Digit select and subtract, highest multiple first.
  always_comb begin
    o_rem   = i_prem;
    o_digit = 2'd0;
    if (i_prem >= i_d3) begin
      o_rem   = i_prem - i_d3;
      o_digit = 2'd3;
    end else if (i_prem >= i_d2) begin
      o_rem   = i_prem - i_d2;
      o_digit = 2'd2;
    end else if (i_prem >= i_d) begin
      o_rem   = i_prem - i_d;
      o_digit = 2'd1;
    end
  end

endmodule

// File: rtl/radix4_divider_32bit.sv
// Iterative 32-bit radix-4 divider, signed (DIV/REM) or unsigned (DIVU/REMU).
module radix4_divider_32bit
  import pe_arith_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy,
  output logic            done
);

  div_state_t       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_dvd;
  logic [XLEN+1:0]  r_prem;
  logic [XLEN+1:0]  r_d;
  logic [XLEN+1:0]  r_d3;
  logic [XLEN-1:0]  r_quo;
  logic             r_qneg;
  logic             r_rneg;
  logic [XLEN-1:0]  r_quotient;
  logic [XLEN-1:0]  r_remainder;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_dvd_mag;
  logic [XLEN-1:0]  w_dvs_mag;
  logic [XLEN+1:0]  w_d2;
  logic [XLEN+1:0]  w_shift;
  logic [XLEN+1:0]  w_rem;
  logic [1:0]       w_digit;
  logic [XLEN-1:0]  w_rem_lo;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_div0    = (divisor == '0);
  assign w_ovf     = is_signed && (dividend == OVF_QUOT) && (divisor == OVF_DIVISOR);
  assign w_special = w_div0 || w_ovf;
  assign w_dvd_mag = mag(dividend, is_signed);
  assign w_dvs_mag = mag(divisor, is_signed);
  assign w_d2      = r_d << 1;
  assign w_shift   = (r_prem << 2) | {{XLEN{1'b0}}, r_dvd[XLEN-1 -: 2]};
  assign w_rem_lo  = r_prem[XLEN-1:0];

  div_r4_step u_step (
    .i_prem  (w_shift),
    .i_d     (r_d),
    .i_d2    (w_d2),
    .i_d3    (r_d3),
    .o_rem   (w_rem),
    .o_digit (w_digit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; special operands skip straight to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = w_special ? ST_DONE : ST_ITER;
      ST_ITER: if (r_cnt == CNT_LAST) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and sign fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_prem      <= '0;
      r_d         <= '0;
      r_d3        <= '0;
      r_quo       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          if (w_special) begin
            r_quotient  <= w_div0 ? DIV0_QUOT : OVF_QUOT;
            r_remainder <= w_div0 ? dividend : '0;
          end else begin
            r_dvd  <= w_dvd_mag;
            r_d    <= {2'b00, w_dvs_mag};
            r_d3   <= {2'b00, w_dvs_mag} + {1'b0, w_dvs_mag, 1'b0};
            r_prem <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_qneg <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_rneg <= is_signed && dividend[XLEN-1];
          end
        end
        ST_ITER: begin
          r_prem <= w_rem;
          r_quo  <= {r_quo[XLEN-3:0], w_digit};
          r_dvd  <= {r_dvd[XLEN-3:0], 2'b00};
          r_cnt  <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          r_quotient  <= r_qneg ? ('0 - r_quo) : r_quo;
          r_remainder <= r_rneg ? ('0 - w_rem_lo) : w_rem_lo;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags: done is registered from DONE so it lands in the IDLE
  // cycle where the next start can already be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (w_accept)                  r_busy <= 1'b1;
      else if (r_state == ST_DONE)   r_busy <= 1'b0;
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
